// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two master ports, the RAM pins and the grant indicator of
// mem_port_arbiter; slave is the arbiter's view, master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [DW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [3:0]    m0_sel;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic [DW-1:0] m1_addr;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          ram_ce;
    logic          ram_we;
    logic [DW-1:0] ram_addr;
    logic [DW-1:0] ram_data_o;
    logic [3:0]    ram_sel;
    logic [DW-1:0] ram_data_i;

    logic          grant_m1;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
        output m0_ack, m0_rdata,
        input  m1_req, m1_addr,
        output m1_ack, m1_rdata,
        output ram_ce, ram_we, ram_addr, ram_data_o, ram_sel,
        input  ram_data_i,
        output grant_m1
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
        input  m0_ack, m0_rdata,
        output m1_req, m1_addr,
        input  m1_ack, m1_rdata,
        input  ram_ce, ram_we, ram_addr, ram_data_o, ram_sel,
        output ram_data_i,
        input  grant_m1
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single-port data RAM: fixed M0 priority with a
// burst guard for M1, IDLE/BUSY/RESP access sequencing and per-master held read data.
module mem_port_arbiter #(
    parameter int DW          = 32,
    parameter int WAIT_STATES = 1,
    parameter int MAX_BURST   = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    localparam int              BW          = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_LIMIT = BW'(MAX_BURST);
    localparam logic [3:0]      WAIT_LOAD   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    wcnt;
    logic [BW-1:0] bcnt;
    logic          pick_m1;
    logic [DW-1:0] rd_word;

    assign rd_word = bus.ram_data_i;

    // M1 only overtakes a requesting M0 once M0 has used up its burst allowance.
    always_comb begin
        // NOTE: default first so every path assigns pick_m1; otherwise a latch is inferred.
        pick_m1 = 1'b0;
        if (bus.m1_req && (!bus.m0_req || bcnt == BURST_LIMIT)) begin
            pick_m1 = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            wcnt           <= '0;
            bcnt           <= '0;
            bus.ram_ce     <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_data_o <= '0;
            bus.ram_sel    <= '0;
            bus.m0_ack     <= 1'b0;
            bus.m1_ack     <= 1'b0;
            bus.m0_rdata   <= '0;
            bus.m1_rdata   <= '0;
            bus.grant_m1   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.m1_req) begin
                        bcnt <= '0;
                    end
                    if (bus.m0_req || bus.m1_req) begin
                        state        <= BUSY;
                        wcnt         <= WAIT_LOAD;
                        bus.ram_ce   <= 1'b1;
                        bus.grant_m1 <= pick_m1;
                        if (pick_m1) begin
                            bus.ram_we     <= 1'b0;
                            bus.ram_addr   <= bus.m1_addr;
                            bus.ram_data_o <= '0;
                            bus.ram_sel    <= 4'b1111;
                            bcnt           <= '0;
                        end else begin
                            bus.ram_we     <= bus.m0_we;
                            bus.ram_addr   <= bus.m0_addr;
                            bus.ram_data_o <= bus.m0_wdata;
                            bus.ram_sel    <= bus.m0_sel;
                            // Only grants that make M1 wait count toward the burst.
                            if (bus.m1_req && bcnt != BURST_LIMIT) begin
                                bcnt <= bcnt + 1'b1;
                            end
                        end
                    end
                end

                BUSY: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        bus.ram_ce <= 1'b0;
                        bus.ram_we <= 1'b0;
                        state      <= RESP;
                        if (bus.grant_m1) begin
                            bus.m1_ack   <= 1'b1;
                            bus.m1_rdata <= rd_word;
                        end else begin
                            bus.m0_ack <= 1'b1;
                            if (!bus.ram_we) begin
                                bus.m0_rdata <= rd_word;
                            end
                        end
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance with WAIT_STATES=1 and
// MAX_BURST=4, a second with WAIT_STATES=0 for back-to-back timing.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.DW(32)) a_if ();
    mem_port_arbiter_if #(.DW(32)) b_if ();

    mem_port_arbiter #(.DW(32), .WAIT_STATES(1), .MAX_BURST(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(a_if)
    );

    mem_port_arbiter #(.DW(32), .WAIT_STATES(0), .MAX_BURST(4)) dut_ws0 (
        .clk(clk),
        .rst(rst),
        .bus(b_if)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: ram_word = 32'h1111_1111;
            32'h0000_0004: ram_word = 32'h2222_2222;
            32'h0000_0010: ram_word = 32'hDEAD_BEEF;
            32'h0000_0040: ram_word = 32'hCAFE_F00D;
            32'h0000_0044: ram_word = 32'h0BAD_F00D;
            default:       ram_word = addr ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign a_if.ram_data_i = ram_word(a_if.ram_addr);
    assign b_if.ram_data_i = ram_word(b_if.ram_addr);

    typedef struct {
        bit          m1;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];

    task automatic push_a(input bit m1, input logic [31:0] rdata);
        exp_t e;
        e.m1 = m1;
        e.rdata = rdata;
        sb_a.push_back(e);
    endtask

    task automatic push_b(input bit m1, input logic [31:0] rdata);
        exp_t e;
        e.m1 = m1;
        e.rdata = rdata;
        sb_b.push_back(e);
    endtask

    // Pops the expected transaction whenever an ack shows up and compares owner and data.
    task automatic mon(input bit which, input logic m0a, input logic m1a,
                       input logic [31:0] m0r, input logic [31:0] m1r,
                       input logic p0, input logic p1);
        exp_t        e;
        logic [31:0] got;
        if (m0a || m1a) begin
            n_checks++;
            if (m0a && m1a) begin
                n_errors++;
                $display("FAIL both_ack inst=%0d: got m0_ack=1 m1_ack=1, expected one ack", which);
            end
            n_checks++;
            if ((m0a && p0) || (m1a && p1)) begin
                n_errors++;
                $display("FAIL ack_width inst=%0d: ack high two cycles, expected one-cycle pulse", which);
            end
            n_checks++;
            if ((which == 1'b0 && sb_a.size() == 0) || (which == 1'b1 && sb_b.size() == 0)) begin
                n_errors++;
                $display("FAIL spurious_ack inst=%0d: got ack m0=%0b m1=%0b, expected none", which, m0a, m1a);
            end else begin
                e = (which == 1'b0) ? sb_a.pop_front() : sb_b.pop_front();
                n_checks++;
                if (m1a !== e.m1) begin
                    n_errors++;
                    $display("FAIL grant_order inst=%0d: got master M%0d, expected M%0d", which, m1a, e.m1);
                end
                got = m1a ? m1r : m0r;
                n_checks++;
                if (got !== e.rdata) begin
                    n_errors++;
                    $display("FAIL rdata inst=%0d M%0d: got %h, expected %h", which, m1a, got, e.rdata);
                end
            end
        end
    endtask

    initial begin
        logic pa0, pa1, pb0, pb1;
        pa0 = 1'b0; pa1 = 1'b0; pb0 = 1'b0; pb1 = 1'b0;
        forever begin
            @(negedge clk);
            mon(1'b0, a_if.m0_ack, a_if.m1_ack, a_if.m0_rdata, a_if.m1_rdata, pa0, pa1);
            mon(1'b1, b_if.m0_ack, b_if.m1_ack, b_if.m0_rdata, b_if.m1_rdata, pb0, pb1);
            pa0 = a_if.m0_ack; pa1 = a_if.m1_ack;
            pb0 = b_if.m0_ack; pb1 = b_if.m1_ack;
        end
    end

    task automatic idle_inputs();
        a_if.m0_req = 1'b0; a_if.m0_we = 1'b0; a_if.m0_addr = '0; a_if.m0_wdata = '0; a_if.m0_sel = '0;
        a_if.m1_req = 1'b0; a_if.m1_addr = '0;
        b_if.m0_req = 1'b0; b_if.m0_we = 1'b0; b_if.m0_addr = '0; b_if.m0_wdata = '0; b_if.m0_sel = '0;
        b_if.m1_req = 1'b0; b_if.m1_addr = '0;
    endtask

    task automatic test_reset();
        logic [136:0] outs_a, outs_b;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            outs_a = {a_if.ram_ce, a_if.ram_we, a_if.ram_addr, a_if.ram_data_o, a_if.ram_sel,
                      a_if.m0_ack, a_if.m1_ack, a_if.m0_rdata, a_if.m1_rdata, a_if.grant_m1};
            outs_b = {b_if.ram_ce, b_if.ram_we, b_if.ram_addr, b_if.ram_data_o, b_if.ram_sel,
                      b_if.m0_ack, b_if.m1_ack, b_if.m0_rdata, b_if.m1_rdata, b_if.grant_m1};
            n_checks++;
            if (outs_a !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs_a cycle %0d: got %h, expected 0", i, outs_a);
            end
            n_checks++;
            if (outs_b !== '0) begin
                n_errors++;
                $display("FAIL reset_outputs_b cycle %0d: got %h, expected 0", i, outs_b);
            end
            a_if.m0_req = ~a_if.m0_req;
            a_if.m1_req = (i % 2 == 0);
            b_if.m1_req = ~b_if.m1_req;
            a_if.m0_addr = 32'h100 + 32'(i);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_if.ram_ce, a_if.m0_ack, a_if.m1_ack, b_if.ram_ce, b_if.m0_ack, b_if.m1_ack} !== 6'b0) begin
                n_errors++;
                $display("FAIL post_reset_idle cycle %0d: got ce/acks active, expected all 0", i);
            end
        end
    endtask

    task automatic test_m0_read();
        int ce_cnt, lat, bad_we, saw_m1;
        ce_cnt = 0; lat = 0; bad_we = 0; saw_m1 = 0;
        push_a(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        a_if.m0_we = 1'b0; a_if.m0_addr = 32'h10; a_if.m0_wdata = '0; a_if.m0_sel = 4'hF;
        a_if.m0_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (a_if.ram_ce) begin
                ce_cnt++;
                if (a_if.ram_we !== 1'b0 || a_if.ram_addr !== 32'h10) bad_we++;
            end
            if (a_if.m1_ack) saw_m1++;
            if (a_if.m0_ack) begin
                lat = i;
                break;
            end
        end
        a_if.m0_req = 1'b0;
        n_checks++;
        if (lat != 3) begin
            n_errors++;
            $display("FAIL m0_read_latency: got %0d cycles (0 = timeout), expected 3", lat);
        end
        n_checks++;
        if (ce_cnt != 2) begin
            n_errors++;
            $display("FAIL m0_read_ce_cycles: got %0d, expected 2", ce_cnt);
        end
        n_checks++;
        if (bad_we != 0) begin
            n_errors++;
            $display("FAIL m0_read_ram_pins: got %0d bad ce cycles, expected 0", bad_we);
        end
        n_checks++;
        if (saw_m1 != 0) begin
            n_errors++;
            $display("FAIL m0_read_m1_ack: got %0d m1 acks, expected 0", saw_m1);
        end
    endtask

    task automatic test_m0_write();
        int ce_cnt, lat, bad;
        ce_cnt = 0; lat = 0; bad = 0;
        push_a(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        a_if.m0_we = 1'b1; a_if.m0_addr = 32'h20; a_if.m0_wdata = 32'h1234_5678; a_if.m0_sel = 4'b0011;
        a_if.m0_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (a_if.ram_ce) begin
                ce_cnt++;
                if ({a_if.ram_we, a_if.ram_addr, a_if.ram_data_o, a_if.ram_sel} !==
                    {1'b1, 32'h20, 32'h1234_5678, 4'b0011}) bad++;
            end
            if (a_if.m0_ack) begin
                lat = i;
                break;
            end
        end
        a_if.m0_req = 1'b0;
        a_if.m0_we = 1'b0;
        n_checks++;
        if (lat != 3) begin
            n_errors++;
            $display("FAIL m0_write_latency: got %0d cycles (0 = timeout), expected 3", lat);
        end
        n_checks++;
        if (ce_cnt != 2) begin
            n_errors++;
            $display("FAIL m0_write_ce_cycles: got %0d, expected 2", ce_cnt);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL m0_write_ram_pins: got %0d bad ce cycles, expected 0", bad);
        end
    endtask

    task automatic test_burst();
        int acks, m1_ce, bad, stale;
        acks = 0; m1_ce = 0; bad = 0; stale = 0;
        for (int i = 0; i < 4; i++) push_a(1'b0, 32'hDEAD_BEEF);
        push_a(1'b1, 32'hCAFE_F00D);
        push_a(1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        a_if.m0_we = 1'b0; a_if.m0_addr = 32'h10; a_if.m0_sel = 4'hF; a_if.m0_req = 1'b1;
        a_if.m1_addr = 32'h40; a_if.m1_req = 1'b1;
        for (int i = 0; i < 60 && acks < 6; i++) begin
            @(negedge clk);
            if (a_if.ram_ce && a_if.grant_m1) begin
                m1_ce++;
                if (a_if.ram_sel !== 4'b1111 || a_if.ram_we !== 1'b0 || a_if.ram_addr !== 32'h40) bad++;
            end
            if (a_if.m0_ack || a_if.m1_ack) acks++;
        end
        a_if.m0_req = 1'b0;
        a_if.m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_if.ram_ce) stale++;
        end
        n_checks++;
        if (acks != 6) begin
            n_errors++;
            $display("FAIL burst_ack_count: got %0d, expected 6", acks);
        end
        n_checks++;
        if (m1_ce != 2) begin
            n_errors++;
            $display("FAIL burst_m1_ce_cycles: got %0d, expected 2", m1_ce);
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL burst_m1_ram_pins: got %0d bad cycles, expected 0", bad);
        end
        n_checks++;
        if (stale != 0) begin
            n_errors++;
            $display("FAIL burst_stale_grant: got %0d ce cycles after drop, expected 0", stale);
        end
    endtask

    task automatic test_reset_mid_busy();
        int seen, lat;
        seen = 0; lat = 0;
        @(negedge clk);
        a_if.m0_we = 1'b0; a_if.m0_addr = 32'h10; a_if.m0_sel = 4'hF; a_if.m0_req = 1'b1;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (a_if.ram_ce) seen = 1;
        end
        n_checks++;
        if (seen == 0) begin
            n_errors++;
            $display("FAIL mid_busy_start: got no ram_ce, expected access in progress");
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({a_if.ram_ce, a_if.m0_ack, a_if.m1_ack} !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_busy_async_drop: got ce/ack=%b, expected 000",
                     {a_if.ram_ce, a_if.m0_ack, a_if.m1_ack});
        end
        repeat (2) @(negedge clk);
        a_if.m0_req = 1'b0;
        rst = 1'b1;
        push_a(1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        a_if.m1_addr = 32'h44; a_if.m1_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (a_if.m1_ack) begin
                lat = i;
                break;
            end
        end
        a_if.m1_req = 1'b0;
        n_checks++;
        if (lat != 3) begin
            n_errors++;
            $display("FAIL post_reset_m1_latency: got %0d cycles (0 = timeout), expected 3", lat);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, ce_cnt;
        t1 = -1; t2 = -1; ce_cnt = 0;
        push_b(1'b1, 32'h1111_1111);
        push_b(1'b1, 32'h2222_2222);
        @(negedge clk);
        b_if.m1_addr = 32'h0; b_if.m1_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_if.ram_ce) ce_cnt++;
            if (b_if.m1_ack) begin
                t1 = cyc;
                break;
            end
        end
        b_if.m1_addr = 32'h4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_if.ram_ce) ce_cnt++;
            if (b_if.m1_ack) begin
                t2 = cyc;
                break;
            end
        end
        b_if.m1_req = 1'b0;
        n_checks++;
        if (t1 < 0 || t2 < 0 || t2 - t1 != 3) begin
            n_errors++;
            $display("FAIL b2b_ack_spacing: got t1=%0d t2=%0d, expected spacing 3", t1, t2);
        end
        n_checks++;
        if (ce_cnt != 2) begin
            n_errors++;
            $display("FAIL b2b_ce_cycles: got %0d, expected 2", ce_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        test_reset();
        test_m0_read();
        test_m0_write();
        test_burst();
        test_reset_mid_busy();
        test_back_to_back();
        repeat (4) @(negedge clk);
        n_checks++;
        if (sb_a.size() != 0 || sb_b.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", sb_a.size(), sb_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
